// File: rtl/pwm_deadtime.sv
// pwm_deadtime: splits one PWM waveform into a complementary high-side /
// low-side pair and inserts a programmable dead time (both off) at every
// transition so the two outputs are never on together.
// Latency: outputs are a registered decode of the next state; a pwm_in edge
// turns the active side off one clock later, and the new side comes on
// `deadtime` clocks after that. No backpressure.
//
// Ports:
//   clk           rising-edge system clock
//   reset         synchronous, active-high
//   enable        1 = follow pwm_in, 0 = both outputs off (via IDLE)
//   pwm_in        upstream PWM waveform (same clock domain, glitch-free)
//   deadtime      dead time in clocks, sampled on entry to a dead-time state
//   out_hi/out_lo high-side / low-side drive (registered, mutually exclusive)
//   dt_active     1 while in a dead-time state (registered)
//
// Build option: define PWM_DEADTIME_FAULT_EN to add the fault inputs
// (fault, fault_clear), the sticky FAULT state and the fault_latched output.

module pwm_deadtime #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic [WIDTH-1:0] deadtime,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic             fault,
  input  logic             fault_clear,
  output logic             fault_latched,
`endif
  output logic             out_hi,
  output logic             out_lo,
  output logic             dt_active
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LO_ON    = 3'd1,
    HI_ON    = 3'd2,
    DT_TO_HI = 3'd3,
    DT_TO_LO = 3'd4
`ifdef PWM_DEADTIME_FAULT_EN
    ,
    FAULT    = 3'd5
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  // Set when the current dead-time interval was entered from an ON state.
  // An abort may then fall back to that ON state, because the opposite side
  // never turned on. When the interval was entered from IDLE there is no
  // side to fall back to, so an abort restarts a full dead time towards the
  // newly requested side instead.
  logic             src_on, src_on_nxt;

  logic             dt_zero;
  logic [WIDTH-1:0] dt_load;

  assign dt_zero = (deadtime == '0);
  // Only used when deadtime != 0, so the subtraction never wraps.
  assign dt_load = deadtime - WIDTH'(1);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    src_on_nxt = src_on;

`ifdef PWM_DEADTIME_FAULT_EN
    if (fault) begin
      // Fault overrides everything but reset, including enable.
      state_nxt  = FAULT;
      cnt_nxt    = '0;
      src_on_nxt = 1'b0;
    end else if (state == FAULT) begin
      // Sticky: leaves only on a clear with the fault input already gone.
      if (fault_clear) begin
        state_nxt = IDLE;
      end
    end else
`endif
    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      src_on_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          src_on_nxt = 1'b0;
          if (pwm_in) begin
            if (dt_zero) begin
              state_nxt = HI_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_HI;
              cnt_nxt   = dt_load;
            end
          end else begin
            if (dt_zero) begin
              state_nxt = LO_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_LO;
              cnt_nxt   = dt_load;
            end
          end
        end

        LO_ON: begin
          if (pwm_in) begin
            src_on_nxt = 1'b1;
            if (dt_zero) begin
              state_nxt = HI_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_HI;
              cnt_nxt   = dt_load;
            end
          end
        end

        HI_ON: begin
          if (!pwm_in) begin
            src_on_nxt = 1'b1;
            if (dt_zero) begin
              state_nxt = LO_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_LO;
              cnt_nxt   = dt_load;
            end
          end
        end

        DT_TO_HI: begin
          if (!pwm_in) begin
            if (src_on) begin
              // Abort: low side was on before and high never came on.
              state_nxt = LO_ON;
              cnt_nxt   = '0;
            end else if (dt_zero) begin
              state_nxt = LO_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_LO;
              cnt_nxt   = dt_load;
            end
          end else if (cnt == '0) begin
            state_nxt = HI_ON;
          end else begin
            cnt_nxt = cnt - WIDTH'(1);
          end
        end

        DT_TO_LO: begin
          if (pwm_in) begin
            if (src_on) begin
              // Abort: high side was on before and low never came on.
              state_nxt = HI_ON;
              cnt_nxt   = '0;
            end else if (dt_zero) begin
              state_nxt = HI_ON;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DT_TO_HI;
              cnt_nxt   = dt_load;
            end
          end else if (cnt == '0) begin
            state_nxt = LO_ON;
          end else begin
            cnt_nxt = cnt - WIDTH'(1);
          end
        end

        default: begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          src_on_nxt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State register and registered output decode of the next state, so
  // out_hi / out_lo can never glitch or overlap.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      src_on    <= 1'b0;
      out_hi    <= 1'b0;
      out_lo    <= 1'b0;
      dt_active <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_latched <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      src_on    <= src_on_nxt;
      out_hi    <= (state_nxt == HI_ON);
      out_lo    <= (state_nxt == LO_ON);
      dt_active <= (state_nxt == DT_TO_HI) || (state_nxt == DT_TO_LO);
`ifdef PWM_DEADTIME_FAULT_EN
      fault_latched <= (state_nxt == FAULT);
`endif
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed, table-driven bench for pwm_deadtime plus hand
// sequences for aborts, enable drop, maximum dead time and a PWM chain.
// Outputs are sampled 1 time unit after each rising edge.

module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] deadtime = 8'd0;
  logic       out_hi, out_lo, dt_active;
`ifdef PWM_DEADTIME_FAULT_EN
  logic       fault = 1'b0;
  logic       fault_clear = 1'b0;
  logic       fault_latched;
`endif

  int passed = 0;
  int total  = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .deadtime  (deadtime),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault         (fault),
    .fault_clear   (fault_clear),
    .fault_latched (fault_latched),
`endif
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .dt_active (dt_active)
  );

  // Both-on must never be observed on any cycle.
  always @(negedge clk) begin
    if (out_hi && out_lo) overlap++;
  end

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       pwm;
    logic [7:0] dt;
    logic [2:0] exp;   // {out_hi, out_lo, dt_active} after the edge
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic e, input logic p,
                              input logic [7:0] d, input logic [2:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.pwm = p; v.dt = d; v.exp = x;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req)
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else
      passed++;
  endtask

  // Steps until out_hi rises (bounded); reports dead-time cycles seen.
  task automatic wait_hi(input int budget, output int dtn, output int rose);
    dtn  = 0;
    rose = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (out_hi) begin
        rose = 1;
        break;
      end
      if (dt_active) dtn++;
    end
  endtask

  initial begin
    int dtn, rose;
    int hi_run, lo_run, last_hi, last_lo;
    logic [7:0] pcnt;

    // Dead-time timing, abort, zero dead time, enable drop, reset, dt change
    vecs[0]  = mk(1, 0, 0, 8'd3, 3'b000);  // reset state
    vecs[1]  = mk(0, 1, 0, 8'd3, 3'b001);  // enable -> DT_TO_LO
    vecs[2]  = mk(0, 1, 0, 8'd3, 3'b001);
    vecs[3]  = mk(0, 1, 0, 8'd3, 3'b001);
    vecs[4]  = mk(0, 1, 0, 8'd3, 3'b010);  // lo on 4 clocks after enable
    vecs[5]  = mk(0, 1, 0, 8'd3, 3'b010);
    vecs[6]  = mk(0, 1, 1, 8'd3, 3'b001);  // lo off next edge
    vecs[7]  = mk(0, 1, 1, 8'd3, 3'b001);
    vecs[8]  = mk(0, 1, 1, 8'd3, 3'b001);
    vecs[9]  = mk(0, 1, 1, 8'd3, 3'b100);  // hi on after 3 dead clocks
    vecs[10] = mk(0, 1, 1, 8'd3, 3'b100);
    vecs[11] = mk(0, 1, 0, 8'd3, 3'b001);  // start towards lo
    vecs[12] = mk(0, 1, 1, 8'd3, 3'b100);  // abort back to hi
    vecs[13] = mk(0, 1, 1, 8'd3, 3'b100);
    vecs[14] = mk(0, 1, 0, 8'd0, 3'b010);  // zero dead time: direct swap
    vecs[15] = mk(0, 1, 1, 8'd0, 3'b100);
    vecs[16] = mk(0, 1, 1, 8'd0, 3'b100);
    vecs[17] = mk(0, 1, 0, 8'd0, 3'b010);
    vecs[18] = mk(0, 0, 0, 8'd0, 3'b000);  // enable low -> off
    vecs[19] = mk(0, 1, 1, 8'd0, 3'b100);  // from IDLE, dt=0 -> direct
    vecs[20] = mk(0, 1, 0, 8'd2, 3'b001);
    vecs[21] = mk(1, 1, 0, 8'd2, 3'b000);  // reset mid-count
    vecs[22] = mk(0, 1, 0, 8'd2, 3'b001);
    vecs[23] = mk(0, 1, 0, 8'd2, 3'b001);
    vecs[24] = mk(0, 1, 0, 8'd2, 3'b010);
    vecs[25] = mk(0, 1, 1, 8'd2, 3'b001);
    vecs[26] = mk(0, 1, 1, 8'd7, 3'b001);  // dt change ignored mid-count
    vecs[27] = mk(0, 1, 1, 8'd7, 3'b100);

    for (int i = 0; i < NVEC; i++) begin
      reset    = vecs[i].rst;
      enable   = vecs[i].en;
      pwm_in   = vecs[i].pwm;
      deadtime = vecs[i].dt;
      step();
      check($sformatf("vec%0d {hi,lo,dt}", i),
            int'({out_hi, out_lo, dt_active}), int'(vecs[i].exp));
    end

    // Short pulse swallowed: deadtime=6, pwm high for 2 clocks.
    pwm_in = 1'b0; deadtime = 8'd0;
    step();
    check("abort pre lo", int'(out_lo), 1);
    deadtime = 8'd6; pwm_in = 1'b1;
    step();
    check("abort dt1", int'({out_hi, out_lo, dt_active}), 1);
    step();
    check("abort dt2", int'({out_hi, out_lo, dt_active}), 1);
    pwm_in = 1'b0;
    step();
    check("abort lo back", int'({out_hi, out_lo, dt_active}), 2);

    // Enable drop mid dead time, then full dead time on re-enable.
    deadtime = 8'd10; pwm_in = 1'b1;
    repeat (5) step();
    check("mid count dt", int'(dt_active), 1);
    enable = 1'b0;
    step();
    check("enable drop off", int'({out_hi, out_lo, dt_active}), 0);
    enable = 1'b1;
    wait_hi(40, dtn, rose);
    check("reenable hi rose", rose, 1);
    check("reenable dead clocks", dtn, 10);

    // Maximum dead time: counts 254..0 without wrapping.
    pwm_in = 1'b0; deadtime = 8'd0;
    step();
    deadtime = 8'd255; pwm_in = 1'b1;
    wait_hi(400, dtn, rose);
    check("max dt hi rose", rose, 1);
    check("max dt dead clocks", dtn, 255);

    // PWM chain: 8-bit counter PWM, level 0x40, deadtime 5.
    deadtime = 8'd5;
    pcnt = 8'd0;
    hi_run = 0; lo_run = 0; last_hi = 0; last_lo = 0;
    for (int c = 0; c < 1024; c++) begin
      pwm_in = (pcnt < 8'h40);
      step();
      pcnt = pcnt + 8'd1;
      if (out_hi) hi_run++;
      else if (hi_run > 0) begin last_hi = hi_run; hi_run = 0; end
      if (out_lo) lo_run++;
      else if (lo_run > 0) begin last_lo = lo_run; lo_run = 0; end
    end
    check("chain hi width", last_hi, 64 - 5);
    check("chain lo width", last_lo, 192 - 5);

`ifdef PWM_DEADTIME_FAULT_EN
    deadtime = 8'd3; pwm_in = 1'b1;
    repeat (8) step();
    check("fault pre hi", int'(out_hi), 1);
    fault = 1'b1;
    step();
    check("fault hi off", int'({out_hi, out_lo, fault_latched}), 1);
    fault = 1'b0;
    step();
    check("fault sticky", int'({out_hi, out_lo, fault_latched}), 1);
    fault = 1'b1; fault_clear = 1'b1;
    step();
    check("clear ignored", int'(fault_latched), 1);
    fault = 1'b0;
    step();
    check("clear exits", int'({out_hi, out_lo, fault_latched}), 0);
    fault_clear = 1'b0;
    wait_hi(20, dtn, rose);
    check("post fault dead clocks", dtn, 3);
`endif

    check("no overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Complementary-output stage placed directly downstream of each `pwm` instance in the PWM peripheral.
- Converts one PWM waveform into a high-side/low-side pair suitable for a half-bridge.
- Inserts a programmable dead time (both outputs off) at every transition, so the two outputs are never high together.
- The dead-time value comes from a peripheral register; the outputs drive `uo_out` pins in place of the raw PWM.

Parameters:
- WIDTH, 8, bit width of the dead-time count (maximum dead time is 2^WIDTH-1 clocks).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = drive outputs from `pwm_in`; 0 = both outputs off.
- pwm_in  input  1  PWM waveform from the upstream `pwm` generator (same clock domain, glitch-free).
- deadtime  input  WIDTH  dead time in clocks; sampled on entry to a dead-time state.
- out_hi  output  1  high-side drive, registered.
- out_lo  output  1  low-side drive, registered.
- dt_active  output  1  1 while in a dead-time state, registered.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset:
  - state=IDLE, counter=0, out_hi=0, out_lo=0, dt_active=0.
  - Reset asserted mid-operation forces these values on the next edge.
- Outputs are a registered decode of the next state:
  - IDLE: hi=0, lo=0.
  - LO_ON: lo=1.
  - HI_ON: hi=1.
  - DT_TO_HI and DT_TO_LO: hi=0, lo=0, dt_active=1.
- Invariant: out_hi & out_lo == 0 on every cycle, including during reset and enable changes.
- enable=0 in any state: next state IDLE; outputs 0 one cycle later.
- IDLE with enable=1:
  - Next state DT_TO_HI if pwm_in=1, else DT_TO_LO.
  - Counter loaded with deadtime-1.
  - If deadtime=0, go directly to HI_ON or LO_ON.
  - A full dead time is therefore always applied after enable, reset, or (when compiled in) fault recovery.
- LO_ON with pwm_in=1:
  - deadtime=0: next state HI_ON.
  - Otherwise: DT_TO_HI with counter=deadtime-1.
- HI_ON with pwm_in=0: symmetric, next state DT_TO_LO or LO_ON.
- DT_TO_x, pwm_in still requests x:
  - counter==0: next state x_ON.
  - Otherwise counter decrements by 1.
- Both-off interval is exactly `deadtime` clocks:
  - edge N: pwm_in changes;
  - edge N+1: outputs off;
  - edge N+1+deadtime: new side on.
- DT_TO_x, pwm_in reverts to the previous level (abort):
  - Next state is the source ON state; counter is cleared.
  - This is safe because the opposite side never turned on.
- A deadtime change during counting is ignored; it takes effect at the next dead-time entry.
- Pulses shorter than deadtime on pwm_in are swallowed by the abort rule: outputs stay on the original side or stay off.
- pwm_in constant at 0% or 100% duty: the corresponding side stays on steadily after the initial dead time.
- deadtime=2^WIDTH-1: counter counts from 2^WIDTH-2 down to 0 with no wrap; no arithmetic overflow is possible.

Optional Feature:
- Macro: PWM_DEADTIME_FAULT_EN.
- Defined:
  - Adds ports `fault` (input 1), `fault_clear` (input 1) and `fault_latched` (output 1, reset 0).
  - fault=1 in any non-reset state: next state FAULT, outputs 0, fault_latched=1. This takes priority over enable.
  - FAULT is sticky. It exits to IDLE only on a cycle with fault_clear=1 and fault=0; fault_latched clears at the same edge.
  - fault_clear while fault=1 is ignored.
- Undefined: none of these ports, the FAULT state or its logic exist.

Test Plan:
- Dead-time timing: reset, deadtime=3, enable=1, pwm_in=0 → out_lo rises 4 clocks after enable. Raise pwm_in at cycle 20 → lo=0 at 21, hi=1 at 24, dt_active=1 for cycles 21–23.
- Zero dead time: deadtime=0, pwm_in toggling every 5 clocks → hi and lo swap with 1-clock latency, never both 1, dt_active never set.
- Abort: deadtime=6, pwm_in high for 2 clocks then low → out_hi never rises, out_lo back to 1 two cycles after the pulse start.
- Enable and reset mid-dead-time: deadtime=10, drop enable at count 4 → both outputs 0 next cycle. Re-enable with pwm_in=1 → out_hi rises after a full 10-clock dead time. Asserting reset mid-count gives all outputs 0.
- Real PWM chain: `pwm` instance with level=0x40 and strobe period 0 driving pwm_in, deadtime=5 → each high pulse shortened by 5 clocks on both sides; an assertion checks out_hi & out_lo == 0 over 10k cycles.
- With PWM_DEADTIME_FAULT_EN: fault pulse during HI_ON → out_hi=0 next cycle, fault_latched=1. fault_clear with fault=1 is ignored; fault_clear with fault=0 → IDLE, then full dead time before any output rises.
